// File: rtl/digital_lock_pkg.sv
// Shared definitions for the parametrised digital lock: FSM state
// encodings and a constant-width helper usable in port declarations.
package digital_lock_pkg;

  typedef enum logic [2:0] {
    S_UNLOCKED = 3'd0,
    S_LOCKED   = 3'd1,
    S_CREATE   = 3'd2,
    S_CONFIRM  = 3'd3,
    S_ENTER    = 3'd4,
    S_ERROR    = 3'd5,
    S_LOCKOUT  = 3'd6
  } lockState_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) is 0, so callers
  // that need at least one bit pass value+1 where appropriate.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/digital_lock_multi_key_press_decoder.sv
// Turns the synchronised one-hot key bus into single-cycle press events.
// A press is the first cycle any key is seen after all keys were released,
// so holding a key produces exactly one event. Multi-key presses are
// flagged as invalid and carry no digit meaning.
module key_press_decoder
  import digital_lock_pkg::*;
#(
  parameter int KEY_WIDTH = 4,
  localparam int DIGIT_W = clog2(KEY_WIDTH)
) (
  input  logic                 i_clock,
  input  logic                 i_resetN,
  input  logic [KEY_WIDTH-1:0] i_key,
  output logic                 o_press,
  output logic                 o_valid,
  output logic [DIGIT_W-1:0]   o_digit
);

  logic [KEY_WIDTH-1:0] r_keyQ;
  logic                 w_oneHot;

  // Remember last cycle's keys so a rising "any key" can be detected.
  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      r_keyQ <= '0;
    end else begin
      r_keyQ <= i_key;
    end
  end

  assign o_press  = (|i_key) & ~(|r_keyQ);
  assign w_oneHot = (i_key != '0) && ((i_key & (i_key - KEY_WIDTH'(1))) == '0);
  assign o_valid  = o_press & w_oneHot;

  // Encode the index of the set key; only meaningful when o_valid is high.
  always_comb begin
    o_digit = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (i_key[i]) begin
        o_digit = DIGIT_W'(i);
      end
    end
  end

endmodule

// File: rtl/digital_lock_multi.sv
// Parametrised digital lock: create + confirm a password, lock, unlock by
// re-entering it, and a timed lockout after too many consecutive failures.
// Status flags are decoded directly from the registered state.
module digital_lock_multi
  import digital_lock_pkg::*;
#(
  parameter int PASSWORD_LENGTH = 4,
  parameter int KEY_WIDTH       = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 50000000
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [KEY_WIDTH-1:0]                   key,
  output logic                                   locked,
  output logic                                   error,
  output logic                                   cp_flag,
  output logic                                   confirm_flag,
  output logic                                   ep_flag,
  output logic                                   lockout,
  output logic [clog2(PASSWORD_LENGTH+1)-1:0]    digit_count,
  output logic [clog2(MAX_ATTEMPTS+1)-1:0]       fail_count
);

  localparam int DIGIT_W = clog2(KEY_WIDTH);
  localparam int DCW     = clog2(PASSWORD_LENGTH + 1);
  localparam int FCW     = clog2(MAX_ATTEMPTS + 1);
  localparam int TW      = clog2(LOCKOUT_CYCLES + 1);
  localparam int PW_W    = PASSWORD_LENGTH * DIGIT_W;

  lockState_t          r_state;
  lockState_t          r_return;
  logic [PW_W-1:0]     r_password;
  logic [DCW-1:0]      r_digitCount;
  logic [FCW-1:0]      r_failCount;
  logic                r_mismatch;
  logic [TW-1:0]       r_timer;

  logic                w_press;
  logic                w_valid;
  logic                w_accept;
  logic [DIGIT_W-1:0]  w_digit;
  logic [DIGIT_W-1:0]  w_slot;
  logic                w_lastDigit;
  logic                w_mismatchSoFar;
  logic                w_lastAttempt;

  key_press_decoder #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_decoder (
    .i_clock  (clock),
    .i_resetN (reset),
    .i_key    (key),
    .o_press  (w_press),
    .o_valid  (w_valid),
    .o_digit  (w_digit)
  );

  assign w_accept = w_press & w_valid;

  // Select the stored digit for the slot currently being compared.
  always_comb begin
    w_slot = '0;
    for (int i = 0; i < PASSWORD_LENGTH; i++) begin
      if (r_digitCount == DCW'(i)) begin
        w_slot = r_password[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_lastDigit     = (r_digitCount == DCW'(PASSWORD_LENGTH - 1));
  assign w_mismatchSoFar = r_mismatch | (w_digit != w_slot);
  assign w_lastAttempt   = ((int'(r_failCount) + 1) >= MAX_ATTEMPTS);

  // Lock FSM together with password store, digit/fail counters and timer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_UNLOCKED;
      r_return     <= S_UNLOCKED;
      r_password   <= '0;
      r_digitCount <= '0;
      r_failCount  <= '0;
      r_mismatch   <= 1'b0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_UNLOCKED: begin
          if (w_accept) begin
            r_state      <= S_CREATE;
            r_digitCount <= '0;
          end
        end
        S_CREATE: begin
          if (w_accept) begin
            for (int i = 0; i < PASSWORD_LENGTH; i++) begin
              if (r_digitCount == DCW'(i)) begin
                r_password[i*DIGIT_W +: DIGIT_W] <= w_digit;
              end
            end
            if (w_lastDigit) begin
              r_state      <= S_CONFIRM;
              r_digitCount <= '0;
              r_mismatch   <= 1'b0;
            end else begin
              r_digitCount <= r_digitCount + DCW'(1);
            end
          end
        end
        S_CONFIRM: begin
          if (w_accept) begin
            if (w_lastDigit) begin
              r_digitCount <= '0;
              r_mismatch   <= 1'b0;
              if (w_mismatchSoFar) begin
                r_state    <= S_ERROR;
                r_return   <= S_UNLOCKED;
                r_password <= '0;
              end else begin
                r_state <= S_LOCKED;
              end
            end else begin
              r_digitCount <= r_digitCount + DCW'(1);
              r_mismatch   <= w_mismatchSoFar;
            end
          end
        end
        S_LOCKED: begin
          if (w_accept) begin
            r_state      <= S_ENTER;
            r_digitCount <= '0;
            r_mismatch   <= 1'b0;
          end
        end
        S_ENTER: begin
          if (w_accept) begin
            if (w_lastDigit) begin
              r_digitCount <= '0;
              r_mismatch   <= 1'b0;
              if (!w_mismatchSoFar) begin
                r_state     <= S_UNLOCKED;
                r_password  <= '0;
                r_failCount <= '0;
              end else if (!w_lastAttempt) begin
                r_state     <= S_ERROR;
                r_return    <= S_LOCKED;
                r_failCount <= r_failCount + FCW'(1);
              end else begin
                r_state     <= S_LOCKOUT;
                r_failCount <= FCW'(MAX_ATTEMPTS);
                r_timer     <= TW'(LOCKOUT_CYCLES - 1);
              end
            end else begin
              r_digitCount <= r_digitCount + DCW'(1);
              r_mismatch   <= w_mismatchSoFar;
            end
          end
        end
        S_ERROR: begin
          if (w_accept) begin
            r_state      <= r_return;
            r_digitCount <= '0;
          end
        end
        S_LOCKOUT: begin
          if (r_timer == '0) begin
            r_state     <= S_LOCKED;
            r_failCount <= '0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state      <= S_UNLOCKED;
          r_return     <= S_UNLOCKED;
          r_password   <= '0;
          r_digitCount <= '0;
          r_failCount  <= '0;
          r_mismatch   <= 1'b0;
          r_timer      <= '0;
        end
      endcase
    end
  end

  assign locked       = (r_state == S_LOCKED) || (r_state == S_ENTER) ||
                        (r_state == S_LOCKOUT) ||
                        ((r_state == S_ERROR) && (r_return == S_LOCKED));
  assign error        = (r_state == S_ERROR);
  assign cp_flag      = (r_state == S_CREATE);
  assign confirm_flag = (r_state == S_CONFIRM);
  assign ep_flag      = (r_state == S_ENTER);
  assign lockout      = (r_state == S_LOCKOUT);
  assign digit_count  = r_digitCount;
  assign fail_count   = r_failCount;

endmodule
